// File: rtl/display_pkg.sv
// Shared constants for the display scanner: segment table, blank pattern,
// default prescaler divide and the staging register layout.
package display_pkg;

    localparam int unsigned DIV_DEFAULT = 50000;

    localparam logic [1:0] LAST_DIGIT = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low patterns, bit6=a ... bit0=g, indexed by hex value.
    localparam logic [0:15][6:0] SEG_TABLE = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    typedef struct packed {
        logic [3:0] v1;
        logic [3:0] v2;
    } stage_t;

endpackage

// File: rtl/hex2seg7.sv
// Combinational hex-to-seven-segment decoder (active-low outputs).
module hex2seg7
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan.sv
// Digit scanner with frame-synchronous commit of two hex digits.
// Optional blanking input is enabled by defining DISPLAY_SCAN_BLANK_EN.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld,
    input  logic [3:0] v1,
    input  logic [3:0] v2,
`ifdef DISPLAY_SCAN_BLANK_EN
    input  logic       blank,
`endif
    output logic [1:0] e1,
    output logic [6:0] t1,
    output logic [6:0] t2,
    output logic       tick,
    output logic       pend
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             frame_end;
    logic             commit;
    stage_t           stage;
    logic [6:0]       seg1;
    logic [6:0]       seg2;

    assign wrap      = (cnt == CNT_LAST);
    assign frame_end = wrap && (e1 == LAST_DIGIT);
    // A load on the boundary edge never commits itself; only older staging does.
    assign commit    = frame_end && pend;

    // NOTE: sequential state uses non-blocking assignments and the async
    // reset appears in the sensitivity list so it acts without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            e1   <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                cnt <= '0;
                e1  <= e1 + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
            pend  <= 1'b0;
        end else begin
            if (ld) begin
                stage <= '{v1: v1, v2: v2};
                pend  <= 1'b1;
            end else if (commit) begin
                pend  <= 1'b0;
            end
        end
    end

    hex2seg7 u_seg1 (
        .hex (stage.v1),
        .seg (seg1)
    );

    hex2seg7 u_seg2 (
        .hex (stage.v2),
        .seg (seg2)
    );

`ifdef DISPLAY_SCAN_BLANK_EN
    // Committed patterns live underneath the blanking mux so they survive it.
    logic [6:0] shown1;
    logic [6:0] shown2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown1 <= SEG_BLANK;
            shown2 <= SEG_BLANK;
            t1     <= SEG_BLANK;
            t2     <= SEG_BLANK;
        end else begin
            if (commit) begin
                shown1 <= seg1;
                shown2 <= seg2;
            end
            if (blank) begin
                t1 <= SEG_BLANK;
                t2 <= SEG_BLANK;
            end else begin
                t1 <= commit ? seg1 : shown1;
                t2 <= commit ? seg2 : shown2;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1 <= SEG_BLANK;
            t2 <= SEG_BLANK;
        end else if (commit) begin
            t1 <= seg1;
            t2 <= seg2;
        end
    end
`endif

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (DIV=4): frame-level reference model,
// per-cycle comparison, directed scenarios and randomized loads/resets.
module tb_display_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] v1 = '0;
    logic [3:0] v2 = '0;
    logic [1:0] e1;
    logic [6:0] t1;
    logic [6:0] t2;
    logic       tick;
    logic       pend;

    int checks   = 0;
    int failures = 0;

    display_scan #(.DIV(DIV)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ld   (ld),
        .v1   (v1),
        .v2   (v2),
        .e1   (e1),
        .t1   (t1),
        .t2   (t2),
        .tick (tick),
        .pend (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        case (h)
            4'h0: seg_ref = 7'b0000001;
            4'h1: seg_ref = 7'b1001111;
            4'h2: seg_ref = 7'b0010010;
            4'h3: seg_ref = 7'b0000110;
            4'h4: seg_ref = 7'b1001100;
            4'h5: seg_ref = 7'b0100100;
            4'h6: seg_ref = 7'b0100000;
            4'h7: seg_ref = 7'b0001111;
            4'h8: seg_ref = 7'b0000000;
            4'h9: seg_ref = 7'b0000100;
            4'hA: seg_ref = 7'b0001000;
            4'hB: seg_ref = 7'b1100000;
            4'hC: seg_ref = 7'b0110001;
            4'hD: seg_ref = 7'b1000010;
            4'hE: seg_ref = 7'b0110000;
            default: seg_ref = 7'b0111000;
        endcase
    endfunction

    // Reference model: m_k counts clock edges since reset release; scan
    // position is pure arithmetic on m_k, loads follow the commit rules.
    int         m_k = 0;
    logic [3:0] m_s1 = '0;
    logic [3:0] m_s2 = '0;
    logic       m_pend = 1'b0;
    logic [6:0] m_t1 = 7'h7f;
    logic [6:0] m_t2 = 7'h7f;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k    = 0;
            m_s1   = '0;
            m_s2   = '0;
            m_pend = 1'b0;
            m_t1   = 7'h7f;
            m_t2   = 7'h7f;
        end else begin
            if (((m_k + 1) % FRAME) == 0 && m_pend) begin
                m_t1   = seg_ref(m_s1);
                m_t2   = seg_ref(m_s2);
                m_pend = 1'b0;
            end
            if (ld) begin
                m_s1   = v1;
                m_s2   = v2;
                m_pend = 1'b1;
            end
            m_k++;
        end
    end

    always @(negedge clk) begin
        check("model_e1",   32'(e1),   32'((m_k / DIV) % 4));
        check("model_tick", 32'(tick), 32'(m_k > 0 && (m_k % DIV) == 0));
        check("model_pend", 32'(pend), 32'(m_pend));
        check("model_t1",   32'(t1),   32'(m_t1));
        check("model_t2",   32'(t2),   32'(m_t2));
    end

    task automatic goto(input int k);
        int guard = 0;
        while (m_k < k) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                check("goto_timeout", 32'(m_k), 32'(k));
                return;
            end
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b);
        ld = 1'b1;
        v1 = a;
        v2 = b;
        @(negedge clk);
        ld = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_e1",   32'(e1),   32'd0);
        check("rst_t1",   32'(t1),   32'h7f);
        check("rst_t2",   32'(t2),   32'h7f);
        check("rst_pend", 32'(pend), 32'd0);
        rst_n = 1'b1;

        // Release: tick appears exactly after the 4th edge, one cycle wide.
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            check("first_tick", 32'(tick), 32'(n == 4));
        end
        for (int n = 8; n <= 16; n += 4) begin
            goto(n);
            check("free_e1", 32'(e1), 32'((n / 4) % 4));
        end

        // Mid-frame load commits at the next boundary (edge 32).
        goto(18);
        load(4'h1, 4'h8);
        check("ld_pend",    32'(pend), 32'd1);
        check("ld_t1_hold", 32'(t1),   32'h7f);
        goto(31);
        check("pre_commit_t1", 32'(t1), 32'h7f);
        goto(32);
        check("commit_t1",   32'(t1),   32'b1001111);
        check("commit_t2",   32'(t2),   32'b0000000);
        check("commit_pend", 32'(pend), 32'd0);

        // Two loads in one frame: last one wins.
        goto(34);
        load(4'h3, 4'h0);
        goto(39);
        load(4'h5, 4'h0);
        goto(47);
        check("lw_hold_t1", 32'(t1), 32'b1001111);
        goto(48);
        check("lw_t1", 32'(t1), 32'b0100100);
        check("lw_t2", 32'(t2), 32'b0000001);

        // Load on the boundary edge with nothing pending.
        goto(63);
        load(4'hA, 4'h0);
        check("bnd_t1_hold", 32'(t1),   32'b0100100);
        check("bnd_pend",    32'(pend), 32'd1);
        goto(79);
        check("bnd_t1_wait", 32'(t1), 32'b0100100);
        goto(80);
        check("bnd_t1", 32'(t1), 32'b0001000);

        // Reset mid-frame with a pending load: everything clears, no commit.
        goto(82);
        load(4'hF, 4'hF);
        check("rst2_pend_before", 32'(pend), 32'd1);
        goto(86);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_e1",   32'(e1),   32'd0);
        check("rst2_t1",   32'(t1),   32'h7f);
        check("rst2_t2",   32'(t2),   32'h7f);
        check("rst2_pend", 32'(pend), 32'd0);
        check("rst2_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst2_no_commit_t1", 32'(t1),   32'h7f);
        check("rst2_no_commit_p",  32'(pend), 32'd0);

        // Randomized loads and occasional resets, checked by the model.
        for (int i = 0; i < 900; i++) begin
            ld = ($urandom_range(0, 5) == 0);
            v1 = 4'($urandom_range(0, 15));
            v2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        ld = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
